// File: rtl/obc_bitplane_seq.sv
// Bit-serial offset-binary-coded DA sequencer: walks 16 samples MSB plane first
// through an external ROM and shift-accumulates the ROM outputs into one result.
module obc_bitplane_seq #(
  parameter int W     = 16,
  parameter int ACC_W = 32 + W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [16*W-1:0]    in_data,
  output logic [15:0]        slice,
  output logic               m,
  input  logic [31:0]        rom_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

  st_t                   r_st, w_nxt;
  logic [15:0][W-1:0]    r_samp;
  logic [CW-1:0]         r_bitcnt;
  logic [ACC_W-1:0]      r_acc;
  logic                  r_live;
  logic                  r_ov;
  logic                  w_run;
  logic                  w_take;
  logic [ACC_W-1:0]      w_sext;

  assign w_run  = (r_st == RUN);
  assign w_sext = {{(ACC_W-32){rom_in[31]}}, rom_in};
  assign m      = w_run && (r_bitcnt == CW'(W-1));

  for (genvar k = 0; k < 16; k++) begin : g_lane
    assign slice[k] = w_run & r_samp[k][r_bitcnt];
  end

  // r_live keeps in_ready low until the first edge after reset release
  always_comb begin
    w_nxt    = r_st;
    in_ready = 1'b0;
    w_take   = 1'b0;
    case (r_st)
      IDLE: begin
        in_ready = r_live;
        if (in_valid && r_live) begin
          w_take = 1'b1;
          w_nxt  = RUN;
        end
      end
      RUN:     if (r_bitcnt == '0) w_nxt = DONE;
      DONE:    if (r_ov && out_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st     <= IDLE;
      r_samp   <= '0;
      r_bitcnt <= '0;
      r_acc    <= '0;
      r_live   <= 1'b0;
      r_ov     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_st   <= w_nxt;
      if (w_take) begin
        r_samp   <= in_data;
        r_bitcnt <= CW'(W-1);
      end
      if (w_run) begin
        r_acc <= m ? w_sext : {r_acc[ACC_W-2:0], 1'b0} + w_sext;
        if (r_bitcnt != '0) r_bitcnt <= r_bitcnt - 1'b1;
      end
      // result register stage: valid rises one edge after DONE is entered
      if (r_st == DONE) begin
        if (!r_ov)          r_ov <= 1'b1;
        else if (out_ready) r_ov <= 1'b0;
      end
    end
  end

  assign out_valid = r_ov;
  assign out_data  = r_acc;

endmodule
